router_local_port: RTL and testbench

Router-side endpoint of the local network-interface port. Accepts flits that the DMA pushes with `rx`/`data_i`, buffers them in a FIFO, and returns space availability on `credit_o`. Presents buffered flits toward the DMA receive side with `tx`/`data_o` and pops a flit on `credit_i`. Tracks packet framing (header, size, payload) on the popped stream, so the network-on-chip model and the bench can see packet boundaries.

---
 rtl/router_local_port_if.sv | 24 ++
 rtl/router_local_port.sv | 159 +++++++++++++++
 tb/tb_router_local_port.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/router_local_port_if.sv
// Local network-interface port bundle: DMA-to-router flits with credit
// return, and router-to-DMA flits with credit pop.
interface router_local_port_if #(
  parameter int FLIT_WIDTH = 32
);
  logic                  rx;
  logic [FLIT_WIDTH-1:0] data_i;
  logic                  credit_o;
  logic                  tx;
  logic [FLIT_WIDTH-1:0] data_o;
  logic                  credit_i;

  // DMA side: pushes flits, consumes presented flits
  modport master (
    output rx, data_i, credit_i,
    input  credit_o, tx, data_o
  );

  // Router side: buffers pushed flits, presents the head flit
  modport slave (
    input  rx, data_i, credit_i,
    output credit_o, tx, data_o
  );
endinterface

// File: rtl/router_local_port.sv
// Router-side endpoint of the local port: flit FIFO with credit return,
// head-flit presentation, and packet framing on the popped stream.
// Optional statistics counters are built when ROUTER_PORT_STATS_EN is defined;
// otherwise the stats outputs are tied to zero.
//
// Framing states:
//   state     | meaning
//   F_HEADER  | next pop is a header flit; it is latched into dest_out
//   F_SIZE    | next pop is the payload length in flits
//   F_PAYLOAD | popping payload; remaining counts down to the last flit
//   F_ERROR   | unreachable; any illegal encoding falls back to F_HEADER
module router_local_port #(
  parameter int FLIT_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  router_local_port_if.slave    port_if,
  output logic [FLIT_WIDTH-1:0] dest_out,
  output logic [3:0]            frame_state_out,
  output logic                  pkt_end_out,
  output logic                  overflow_out,
  output logic [31:0]           pkt_count_out,
  output logic [31:0]           flit_count_out
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);

  typedef enum logic [3:0] {
    F_HEADER  = 4'b0001,
    F_SIZE    = 4'b0010,
    F_PAYLOAD = 4'b0100,
    F_ERROR   = 4'b1000
  } frame_t;

  logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop;

  frame_t                state_q, state_d;
  logic [FLIT_WIDTH-1:0] remaining_q, remaining_d;
  logic [FLIT_WIDTH-1:0] dest_d;
  logic                  pkt_end_d;

  // Credit keeps one slot spare for the flit already in flight from the sender.
  assign port_if.tx       = (count != '0);
  assign port_if.data_o   = mem[rd_ptr];
  assign port_if.credit_o = (count < (DEPTH_C - CW'(1)));

  assign pop  = port_if.tx & port_if.credit_i;
  assign push = port_if.rx & ((count < DEPTH_C) | pop);

  // Flit storage; contents are not reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= port_if.data_i;
  end

  // Pointers and occupancy; on a full push+pop the write lands in the freed slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a flit arrived with no room and no pop to make room.
  always_ff @(posedge clock) begin
    if (reset)                      overflow_out <= 1'b0;
    else if (port_if.rx && !push)   overflow_out <= 1'b1;
  end

  // Framing next-state: header, size, then payload countdown to zero.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dest_d      = dest_out;
    pkt_end_d   = 1'b0;
    case (state_q)
      F_HEADER: begin
        if (pop) begin
          dest_d  = port_if.data_o;
          state_d = F_SIZE;
        end
      end
      F_SIZE: begin
        if (pop) begin
          remaining_d = port_if.data_o;
          if (port_if.data_o == '0) begin
            state_d   = F_HEADER;
            pkt_end_d = 1'b1;
          end else begin
            state_d = F_PAYLOAD;
          end
        end
      end
      F_PAYLOAD: begin
        if (pop) begin
          remaining_d = remaining_q - FLIT_WIDTH'(1);
          if (remaining_q == FLIT_WIDTH'(1)) begin
            state_d   = F_HEADER;
            pkt_end_d = 1'b1;
          end
        end
      end
      default: state_d = F_HEADER;
    endcase
  end

  // Framing state register and registered end-of-packet pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= F_HEADER;
      remaining_q <= '0;
      dest_out    <= '0;
      pkt_end_out <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dest_out    <= dest_d;
      pkt_end_out <= pkt_end_d;
    end
  end

  assign frame_state_out = state_q;

`ifdef ROUTER_PORT_STATS_EN
  logic [31:0] pkt_cnt_q, flit_cnt_q;

  // Free-running wrap-around counters of accepted flits and completed packets.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      if (push)        flit_cnt_q <= flit_cnt_q + 32'd1;
      if (pkt_end_out) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_count_out  = pkt_cnt_q;
  assign flit_count_out = flit_cnt_q;
`else
  assign pkt_count_out  = 32'd0;
  assign flit_count_out = 32'd0;
`endif

endmodule

// File: tb/tb_router_local_port.sv
// Bench for router_local_port: table-driven packet vectors plus directed
// sequences for reset, fill, overflow, drain and reset mid-packet.
module tb_router_local_port;

  logic        clock;
  logic        reset;
  logic [31:0] dest_out;
  logic [3:0]  frame_state_out;
  logic        pkt_end_out;
  logic        overflow_out;
  logic [31:0] pkt_count_out;
  logic [31:0] flit_count_out;

  int tests = 0;
  int fails = 0;

  router_local_port_if #(.FLIT_WIDTH(32)) lp ();

  router_local_port #(.FLIT_WIDTH(32), .BUFFER_DEPTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .port_if         (lp),
    .dest_out        (dest_out),
    .frame_state_out (frame_state_out),
    .pkt_end_out     (pkt_end_out),
    .overflow_out    (overflow_out),
    .pkt_count_out   (pkt_count_out),
    .flit_count_out  (flit_count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rx;
    logic [31:0] din;
    logic        ci;
    logic        e_tx;
    logic [31:0] e_dout;
    logic [3:0]  e_frame;
    logic        e_end;
    logic [31:0] e_dest;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    reset       = 1'b1;
    lp.rx       = 1'b0;
    lp.credit_i = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [31:0] pushed [$];
  logic        cred_d;
  int          accepted;

  initial begin
    reset       = 1'b1;
    lp.rx       = 1'b0;
    lp.data_i   = '0;
    lp.credit_i = 1'b0;

    // single packet 11/2/A/B then zero-size packet 5/0, credit_i tied high
    vecs[0] = '{1'b1, 32'h11, 1'b1, 1'b1, 32'h11, 4'b0001, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 32'h02, 1'b1, 1'b1, 32'h02, 4'b0010, 1'b0, 32'h11};
    vecs[2] = '{1'b1, 32'h0A, 1'b1, 1'b1, 32'h0A, 4'b0100, 1'b0, 32'h11};
    vecs[3] = '{1'b1, 32'h0B, 1'b1, 1'b1, 32'h0B, 4'b0100, 1'b0, 32'h11};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 4'b0001, 1'b1, 32'h11};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 4'b0001, 1'b0, 32'h11};
    vecs[6] = '{1'b1, 32'h05, 1'b1, 1'b1, 32'h05, 4'b0001, 1'b0, 32'h11};
    vecs[7] = '{1'b1, 32'h00, 1'b1, 1'b1, 32'h00, 4'b0010, 1'b0, 32'h05};
    vecs[8] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 4'b0001, 1'b1, 32'h05};
    vecs[9] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 4'b0001, 1'b0, 32'h05};

    // reset held two cycles
    apply_reset(2);
    check("rst_credit",   64'(lp.credit_o),     64'd1);
    check("rst_tx",       64'(lp.tx),           64'd0);
    check("rst_frame",    64'(frame_state_out), 64'h1);
    check("rst_overflow", 64'(overflow_out),    64'd0);
    check("rst_pkt_end",  64'(pkt_end_out),     64'd0);
    check("rst_dest",     64'(dest_out),        64'd0);
    check("rst_pkt_cnt",  64'(pkt_count_out),   64'd0);
    check("rst_flit_cnt", 64'(flit_count_out),  64'd0);

    // vector table
    for (int i = 0; i < 10; i++) begin
      lp.rx       = vecs[i].rx;
      lp.data_i   = vecs[i].din;
      lp.credit_i = vecs[i].ci;
      step();
      check($sformatf("v%0d_tx", i),      64'(lp.tx),           64'(vecs[i].e_tx));
      if (vecs[i].e_tx)
        check($sformatf("v%0d_data", i),  64'(lp.data_o),       64'(vecs[i].e_dout));
      check($sformatf("v%0d_frame", i),   64'(frame_state_out), 64'(vecs[i].e_frame));
      check($sformatf("v%0d_pkt_end", i), 64'(pkt_end_out),     64'(vecs[i].e_end));
      check($sformatf("v%0d_dest", i),    64'(dest_out),        64'(vecs[i].e_dest));
    end
`ifdef ROUTER_PORT_STATS_EN
    check("stats_pkt",  64'(pkt_count_out),  64'd2);
    check("stats_flit", 64'(flit_count_out), 64'd6);
`else
    check("stats_pkt",  64'(pkt_count_out),  64'd0);
    check("stats_flit", 64'(flit_count_out), 64'd0);
`endif
    check("no_overflow_pkts", 64'(overflow_out), 64'd0);

    // fill with a sender that registers credit one cycle late
    apply_reset(1);
    lp.rx = 1'b0; lp.credit_i = 1'b0;
    cred_d = 1'b0;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      lp.rx     = cred_d;
      lp.data_i = 32'h100 + 32'(i);
      cred_d    = lp.credit_o;
      step();
      if (lp.rx) begin
        accepted++;
        pushed.push_back(lp.data_i);
      end
      check($sformatf("fill%0d_credit", i), 64'(lp.credit_o), 64'(accepted < 7));
      check($sformatf("fill%0d_ovf", i),    64'(overflow_out), 64'd0);
    end
    check("fill_accepted", 64'(accepted), 64'd8);
    check("fill_tx",       64'(lp.tx),    64'd1);

    // forced push while full with no pop
    lp.rx = 1'b1; lp.data_i = 32'hDEAD; lp.credit_i = 1'b0;
    step();
    lp.rx = 1'b0;
    check("ovf_set",    64'(overflow_out), 64'd1);
    check("ovf_credit", 64'(lp.credit_o),  64'd0);
    step();
    check("ovf_sticky", 64'(overflow_out), 64'd1);

    // drain: exactly the 8 accepted flits in order, dropped flit absent
    lp.credit_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("drain%0d_tx", j),   64'(lp.tx),     64'd1);
      check($sformatf("drain%0d_data", j), 64'(lp.data_o), 64'(pushed[j]));
      step();
    end
    lp.credit_i = 1'b0;
    check("drain_empty",    64'(lp.tx),        64'd0);
    check("drain_ovf_kept", 64'(overflow_out), 64'd1);

    // reset mid-packet: header 77, size 3, three payload flits
    apply_reset(1);
    check("ovf_cleared", 64'(overflow_out), 64'd0);
    for (int i = 0; i < 5; i++) begin
      lp.rx = 1'b1;
      lp.data_i = (i == 0) ? 32'h77 : (i == 1) ? 32'd3 : 32'hC0 + 32'(i);
      step();
    end
    lp.rx = 1'b0; lp.credit_i = 1'b1;
    repeat (3) step();
    lp.credit_i = 1'b0;
    check("mid_frame", 64'(frame_state_out), 64'h4);
    check("mid_dest",  64'(dest_out),        64'h77);
    check("mid_tx",    64'(lp.tx),           64'd1);
    apply_reset(1);
    check("mid_rst_tx",    64'(lp.tx),           64'd0);
    check("mid_rst_frame", 64'(frame_state_out), 64'h1);
    check("mid_rst_dest",  64'(dest_out),        64'd0);
    check("mid_rst_cred",  64'(lp.credit_o),     64'd1);
    lp.rx = 1'b1; lp.data_i = 32'h99;
    step();
    lp.rx = 1'b0; lp.credit_i = 1'b1;
    check("post_hdr_data", 64'(lp.data_o), 64'h99);
    step();
    lp.credit_i = 1'b0;
    check("post_dest",  64'(dest_out),        64'h99);
    check("post_frame", 64'(frame_state_out), 64'h2);
    check("post_empty", 64'(lp.tx),           64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
